// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter
//   Packet-granular round-robin arbiter that shares one wide AXIS TX path
//   among PORTS requesters, ahead of the AXIS-to-segmented MAC converter.
//   A port is granted for a whole packet, and its beats are forwarded through
//   a registered output stage. A stall watchdog protects the shared path: if
//   the granted source drops tvalid mid-packet for TIMEOUT cycles, the packet
//   is cut off with an error-flagged tail beat, and the remaining beats of
//   that source's packet are drained and discarded.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   s_axis_*          PORTS packed AXIS slaves (port i at [i*W +: W])
//   m_axis_*          registered AXIS master toward the MAC converter
//   grant_id          index of the currently granted port
//   busy              high in every state except IDLE
//   abort_pulse       one-cycle pulse when the watchdog fires
//   abort_count       saturating count of watchdog aborts
module axis_tx_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS-1:0]              s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [$clog2(PORTS)-1:0]      grant_id,
  output logic                          busy,
  output logic                          abort_pulse,
  output logic [CNT_W-1:0]              abort_count
);

  localparam int GW   = $clog2(PORTS);
  // Watchdog only needs to count up to TIMEOUT; it stops there.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  m_user_q, m_user_d;
  logic                  abort_pulse_q, abort_pulse_d;
  logic [CNT_W-1:0]      abort_cnt_q, abort_cnt_d;

  logic                  ld;
  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic [PORTS-1:0]      s_ready;
  logic                  g_valid;
  logic                  g_last;
  logic                  g_user;
  logic [DATA_WIDTH-1:0] g_data;
  logic [KEEP_WIDTH-1:0] g_keep;
  logic                  hs;
  logic [GW-1:0]         rr_next;

  // Output register may load when it is empty or being consumed this cycle.
  assign ld = !m_valid_q || m_axis_tready;

  // Round-robin pick: first requesting port at or after rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!pick_found && s_axis_tvalid[(int'(rr_q) + i) % PORTS]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(rr_q) + i) % PORTS);
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Select the granted port's sideband and data.
  always_comb begin
    g_valid = s_axis_tvalid[grant_q];
    g_last  = s_axis_tlast[grant_q];
    g_user  = s_axis_tuser[grant_q];
    g_data  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    g_keep  = s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
    rr_next = (grant_q == GW'(PORTS - 1)) ? {GW{1'b0}} : grant_q + GW'(1);
  end

  // Per-port ready: only the granted port, forwarding in PASS, sinking in DRAIN.
  always_comb begin
    s_ready = '0;
    case (state_q)
      ST_PASS:  s_ready[grant_q] = ld;
      ST_DRAIN: s_ready[grant_q] = 1'b1;
      default:  s_ready = '0;
    endcase
  end

  assign s_axis_tready = s_ready;
  assign hs            = g_valid && s_ready[grant_q];

  // Next-state logic for the arbiter FSM, watchdog and output register.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    wd_d          = wd_q;
    m_data_d      = m_data_q;
    m_keep_d      = m_keep_q;
    m_last_d      = m_last_q;
    m_user_d      = m_user_q;
    abort_pulse_d = 1'b0;
    abort_cnt_d   = abort_cnt_q;
    // A consumed or empty register goes empty unless a beat is loaded below.
    if (ld) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_PASS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PASS: begin
        if (hs) begin
          m_data_d  = g_data;
          m_keep_d  = g_keep;
          m_last_d  = g_last;
          m_user_d  = g_user;
          m_valid_d = 1'b1;
          wd_d      = '0;
          if (g_last) begin
            rr_d    = rr_next;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PASS;
          end
        end else if (!g_valid && (TIMEOUT != 0)) begin
          // Source stall; backpressure keeps g_valid high and never counts.
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(TIMEOUT)) begin
            state_d = ST_ABORT;
          end else begin
            state_d = ST_PASS;
          end
        end else begin
          state_d = ST_PASS;
        end
      end

      ST_ABORT: begin
        if (ld) begin
          // Error-flagged tail beat closes the truncated packet downstream.
          m_data_d      = '0;
          m_keep_d      = KEEP_WIDTH'(8'hFF);
          m_last_d      = 1'b1;
          m_user_d      = 1'b1;
          m_valid_d     = 1'b1;
          abort_pulse_d = 1'b1;
          if (abort_cnt_q != {CNT_W{1'b1}}) begin
            abort_cnt_d = abort_cnt_q + CNT_W'(1);
          end else begin
            abort_cnt_d = abort_cnt_q;
          end
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ABORT;
        end
      end

      ST_DRAIN: begin
        if (hs && g_last) begin
          rr_d    = rr_next;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_q          <= '0;
      grant_q       <= '0;
      wd_q          <= '0;
      m_data_q      <= '0;
      m_keep_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_user_q      <= 1'b0;
      abort_pulse_q <= 1'b0;
      abort_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      wd_q          <= wd_d;
      m_data_q      <= m_data_d;
      m_keep_q      <= m_keep_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_user_q      <= m_user_d;
      abort_pulse_q <= abort_pulse_d;
      abort_cnt_q   <= abort_cnt_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign abort_pulse   = abort_pulse_q;
  assign abort_count   = abort_cnt_q;

endmodule
